// File: rtl/md_issue_scheduler_pkg.sv
// Shared constants and slot type for the MD issue scheduler.
package md_issue_scheduler_pkg;
  localparam int DEF_MUL_LAT   = 3;
  localparam int DEF_DIV_LAT   = 32;
  localparam int DEF_WAKE_LEAD = 1;
  localparam int TAG_W         = 5;
  localparam int IDX_W         = 3;
  localparam int INF_W         = 6;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } slot_t;
endpackage

// File: rtl/md_issue_scheduler_if.sv
// Select/launch/writeback signals between the MD issue queue and the scheduler.
interface md_issue_scheduler_if import md_issue_scheduler_pkg::*; ();
  logic             flush;
  logic             sel_en;
  logic [IDX_W-1:0] sel_num;
  logic             sel_is_div;
  logic [TAG_W-1:0] sel_dst;
  logic             sel_ack;
  logic [IDX_W-1:0] ack_num;
  logic             mul_ok;
  logic             div_ok;
  logic             fu_start;
  logic             fu_is_div;
  logic             fu_kill;
  logic             wakeup_en;
  logic [TAG_W-1:0] wakeup_reg;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_reg;
  logic [INF_W-1:0] inflight;

  modport master (
    output flush, sel_en, sel_num, sel_is_div, sel_dst,
    input  sel_ack, ack_num, mul_ok, div_ok, fu_start, fu_is_div, fu_kill,
           wakeup_en, wakeup_reg, wb_valid, wb_reg, inflight
  );

  modport slave (
    input  flush, sel_en, sel_num, sel_is_div, sel_dst,
    output sel_ack, ack_num, mul_ok, div_ok, fu_start, fu_is_div, fu_kill,
           wakeup_en, wakeup_reg, wb_valid, wb_reg, inflight
  );
endinterface

// File: rtl/md_issue_scheduler_ring.sv
// Writeback reservation ring: slot[k] holds the result due k cycles from now.
module md_issue_scheduler_ring
  import md_issue_scheduler_pkg::*;
#(
  parameter  int DEPTH    = DEF_DIV_LAT,
  parameter  int MUL_TAP  = DEF_MUL_LAT,
  parameter  int WAKE_TAP = DEF_WAKE_LEAD,
  localparam int IW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  output slot_t            head_o,
  output slot_t            wake_o,
  output logic             mul_tap_v_o,
  output logic             div_tap_v_o
);
  slot_t [DEPTH:0] slot_q, slot_d;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) slot_d[k] = slot_q[k+1];
    slot_d[DEPTH] = '0;
    // The write lands on a slot the accept check proved empty after the shift.
    if (wr_en) slot_d[wr_idx] = '{v: 1'b1, tag: wr_tag};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot_q <= '0;
    end else begin
      if (wr_en) assert (!slot_q[wr_idx + 1'b1].v);
      slot_q <= slot_d;
    end
  end

  assign head_o      = slot_q[0];
  assign wake_o      = slot_q[WAKE_TAP];
  assign mul_tap_v_o = slot_q[MUL_TAP].v;
  assign div_tap_v_o = slot_q[DEPTH].v;
endmodule

// File: rtl/md_issue_scheduler.sv
// Accept logic, divider occupancy, in-flight count and kill for the shared MD unit.
module md_issue_scheduler
  import md_issue_scheduler_pkg::*;
#(
  parameter int MUL_LAT   = DEF_MUL_LAT,
  parameter int DIV_LAT   = DEF_DIV_LAT,
  parameter int WAKE_LEAD = DEF_WAKE_LEAD
) (
  input logic                 clk,
  input logic                 rst,
  md_issue_scheduler_if.slave bus
);
  localparam int IW = $clog2(DIV_LAT + 1);
  localparam int CW = $clog2(DIV_LAT);

  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             fu_kill_q;
  slot_t            head, wake;
  logic             mul_busy, div_busy;
  logic             mul_ok, div_ok, ack;
  logic [IW-1:0]    wr_idx;

  assign mul_ok = !bus.flush && !mul_busy;
  assign div_ok = !bus.flush && (div_cnt_q == '0) && !div_busy;
  assign ack    = bus.sel_en && (bus.sel_is_div ? div_ok : mul_ok);
  assign wr_idx = bus.sel_is_div ? IW'(DIV_LAT - 1) : IW'(MUL_LAT - 1);

  md_issue_scheduler_ring #(
    .DEPTH(DIV_LAT), .MUL_TAP(MUL_LAT), .WAKE_TAP(WAKE_LEAD)
  ) u_ring (
    .clk(clk), .rst(rst), .clr(bus.flush),
    .wr_en(ack), .wr_idx(wr_idx), .wr_tag(bus.sel_dst),
    .head_o(head), .wake_o(wake),
    .mul_tap_v_o(mul_busy), .div_tap_v_o(div_busy)
  );

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (ack && bus.sel_is_div) div_cnt_d = CW'(DIV_LAT - 1);
    else if (div_cnt_q != '0)  div_cnt_d = div_cnt_q - 1'b1;
    inflight_d = inflight_q;
    if (ack && !head.v)      inflight_d = inflight_q + 1'b1;
    else if (!ack && head.v) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      inflight_q <= '0;
      fu_kill_q  <= 1'b0;
    end else begin
      fu_kill_q <= bus.flush;
      if (bus.flush) begin
        div_cnt_q  <= '0;
        inflight_q <= '0;
      end else begin
        div_cnt_q  <= div_cnt_d;
        inflight_q <= inflight_d;
      end
    end
  end

  assign bus.sel_ack    = ack;
  assign bus.ack_num    = ack ? bus.sel_num : '0;
  assign bus.mul_ok     = mul_ok;
  assign bus.div_ok     = div_ok;
  assign bus.fu_start   = ack;
  assign bus.fu_is_div  = ack && bus.sel_is_div;
  assign bus.fu_kill    = fu_kill_q;
  assign bus.wakeup_en  = wake.v;
  assign bus.wakeup_reg = wake.v ? wake.tag : '0;
  assign bus.wb_valid   = head.v;
  assign bus.wb_reg     = head.v ? head.tag : '0;
  assign bus.inflight   = inflight_q;
endmodule

// File: tb/tb_md_issue_scheduler.sv
// Directed and random select traffic against a cycle-timeline model of MD results.
module tb_md_issue_scheduler;
  import md_issue_scheduler_pkg::*;

  localparam int ML = DEF_MUL_LAT;
  localparam int DL = DEF_DIV_LAT;
  localparam int WL = DEF_WAKE_LEAD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_issue_scheduler_if bus();
  md_issue_scheduler #(.MUL_LAT(ML), .DIV_LAT(DL), .WAKE_LEAD(WL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Each accepted op is just a tag and the absolute cycle its result appears.
  typedef struct { int tag; int ack; int wb; } op_t;
  op_t q[$];
  int  cyc, div_free, errors, checks;
  bit  prev_flush;

  function automatic int tag_at(input int c);
    foreach (q[i]) if (q[i].wb == c) return q[i].tag;
    return -1;
  endfunction

  function automatic int n_inflight(input int c);
    int n = 0;
    foreach (q[i]) if (q[i].ack < c && q[i].wb >= c) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit en, input bit dv, input int dst, input int num, input bit fl);
    bit   mok, dok, ack;
    int   wbt, wkt;
    op_t  nq[$];
    bus.sel_en = en; bus.sel_is_div = dv; bus.flush = fl;
    bus.sel_dst = TAG_W'(dst); bus.sel_num = IDX_W'(num);
    #2;
    mok = !fl && tag_at(cyc + ML) < 0;
    dok = !fl && cyc >= div_free && tag_at(cyc + DL) < 0;
    ack = en && (dv ? dok : mok);
    wbt = tag_at(cyc);
    wkt = tag_at(cyc + WL);
    chk("mul_ok",     bus.mul_ok,     mok);
    chk("div_ok",     bus.div_ok,     dok);
    chk("sel_ack",    bus.sel_ack,    ack);
    chk("ack_num",    bus.ack_num,    ack ? num : 0);
    chk("fu_start",   bus.fu_start,   ack);
    chk("fu_is_div",  bus.fu_is_div,  ack && dv);
    chk("fu_kill",    bus.fu_kill,    prev_flush);
    chk("wakeup_en",  bus.wakeup_en,  wkt >= 0);
    chk("wakeup_reg", bus.wakeup_reg, wkt >= 0 ? wkt : 0);
    chk("wb_valid",   bus.wb_valid,   wbt >= 0);
    chk("wb_reg",     bus.wb_reg,     wbt >= 0 ? wbt : 0);
    chk("inflight",   bus.inflight,   n_inflight(cyc));
    @(posedge clk); #1;
    if (ack) begin
      q.push_back('{dst, cyc, cyc + (dv ? DL : ML)});
      if (dv) div_free = cyc + DL;
    end
    if (fl) div_free = 0;
    foreach (q[i]) if (q[i].wb > cyc && !(fl && q[i].ack <= cyc)) nq.push_back(q[i]);
    q = nq;
    prev_flush = fl;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.sel_en = 0; bus.sel_is_div = 0; bus.flush = 0; bus.sel_dst = '0; bus.sel_num = '0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_wb_valid",  bus.wb_valid,  0);
    chk("rst_wb_reg",    bus.wb_reg,    0);
    chk("rst_wakeup_en", bus.wakeup_en, 0);
    chk("rst_inflight",  bus.inflight,  0);
    chk("rst_fu_kill",   bus.fu_kill,   0);
    chk("rst_sel_ack",   bus.sel_ack,   0);
    chk("rst_mul_ok",    bus.mul_ok,    1);
    chk("rst_div_ok",    bus.div_ok,    1);
    rst = 1'b0;
    q.delete();
    div_free = 0; prev_flush = 0; cyc = 0;
  endtask

  initial begin
    errors = 0; checks = 0;

    // single multiply, tag 5 at cycle 10
    do_reset(2);
    idle(10);
    step(1, 0, 5, 2, 0);
    idle(6);

    // divide held on select every cycle; only one per DIV_LAT window
    do_reset(1);
    idle(10);
    for (int i = 0; i < 36; i++) step(1, 1, (i == 0) ? 9 : 10, 1, 0);
    idle(4);

    // multiply colliding with a pending divide writeback
    do_reset(1);
    step(1, 1, 7, 3, 0);
    idle(28);
    step(1, 0, 12, 4, 0);
    step(1, 0, 12, 4, 0);
    idle(6);

    // back-to-back multiplies
    do_reset(1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 2, 1, 0);
    step(1, 0, 3, 2, 0);
    idle(6);

    // flush with mul and div in flight, select during flush, div right after
    do_reset(1);
    step(1, 0, 4, 5, 0);
    step(1, 1, 6, 6, 0);
    step(1, 0, 8, 7, 1);
    step(1, 1, 13, 1, 0);
    idle(DL + 3);

    // reset mid-divide, then divide immediately
    do_reset(1);
    step(1, 1, 11, 2, 0);
    idle(10);
    do_reset(1);
    step(1, 1, 14, 3, 0);
    idle(3);

    // random traffic with occasional flushes
    do_reset(1);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
           $urandom_range(0, 49) == 0);
    idle(DL + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
